// File: rtl/cpu_bus_pkg.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module      : cpu_bus_pkg
//  Description : Shared encodings for the CPU-side sram-like bus bridges:
//                transaction FSM states and bus transfer-size codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_bus_pkg;

   // Transfer size codes carried on bus_size
   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   // Bridge FSM state encodings
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   // Enumerated view of the same encodings, handy for debug displays
   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_REQ  = ST_REQ,
      S_WAIT = ST_WAIT,
      S_DONE = ST_DONE
   } state_e;

endpackage : cpu_bus_pkg
`default_nettype wire

// File: rtl/wen_to_size.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module      : wen_to_size
//  Description : Combinational decoder from a 4-bit byte-write-enable mask to
//                a 2-bit bus transfer size. Reads (0000) and full-word
//                writes map to word; irregular masks fall back to word.
//  Revision    : 1.0 - initial release
// ============================================================================
module wen_to_size
   import cpu_bus_pkg::*;
(
   input  logic [3:0] wen,
   output logic [1:0] size
);

   // Single-lane masks are byte accesses, aligned lane pairs are halfwords
   always_comb begin
      size = SZ_WORD;
      case (wen)
         4'b0001, 4'b0010, 4'b0100, 4'b1000: size = SZ_BYTE;
         4'b0011, 4'b1100:                   size = SZ_HALF;
         default:                            size = SZ_WORD;
      endcase
   end

endmodule : wen_to_size
`default_nettype wire

// File: rtl/data_sram_like_bridge.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module      : data_sram_like_bridge
//  Description : Converts the core's single-cycle data-SRAM port into a
//                variable-latency sram-like handshake (req/addr_ok, then
//                data_ok) with one outstanding transaction. Stalls the
//                pipeline until completion and counts stalled cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_sram_like_bridge
   import cpu_bus_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              resetn,
   // core side
   input  logic              cpu_en,
   input  logic [3:0]        cpu_wen,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   // sram-like bus side
   output logic              bus_req,
   output logic              bus_wr,
   output logic [1:0]        bus_size,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic              bus_addr_ok,
   input  logic              bus_data_ok,
   input  logic [DATA_W-1:0] bus_rdata,
   // statistics
   output logic [CNT_W-1:0]  stall_cycles
);

   logic [1:0]        state_q,        state_d;
   logic              bus_req_q,      bus_req_d;
   logic              bus_wr_q,       bus_wr_d;
   logic [1:0]        bus_size_q,     bus_size_d;
   logic [ADDR_W-1:0] bus_addr_q,     bus_addr_d;
   logic [DATA_W-1:0] bus_wdata_q,    bus_wdata_d;
   logic [DATA_W-1:0] cpu_rdata_q,    cpu_rdata_d;
   logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;

   logic [1:0]        wen_size;
   logic              stall;

   // Size is decoded from the live wen so it can be captured with the request
   wen_to_size u_wen_to_size (
      .wen  (cpu_wen),
      .size (wen_size)
   );

   // The pipeline is held from the cycle the access is seen until data_ok;
   // DONE releases it so the MEM stage advances exactly once
   assign stall = ((state_q == ST_IDLE) && cpu_en) ||
                  (state_q == ST_REQ) ||
                  (state_q == ST_WAIT);

   // Transaction FSM: capture in IDLE, hold request in REQ, wait for data,
   // then a single DONE cycle that never re-issues despite cpu_en still high
   always_comb begin
      state_d     = state_q;
      bus_req_d   = bus_req_q;
      bus_wr_d    = bus_wr_q;
      bus_size_d  = bus_size_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      cpu_rdata_d = cpu_rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (cpu_en) begin
               bus_req_d   = 1'b1;
               bus_wr_d    = (cpu_wen != 4'b0000);
               bus_size_d  = wen_size;
               bus_addr_d  = cpu_addr;
               bus_wdata_d = cpu_wdata;
               state_d     = ST_REQ;
            end
         end
         ST_REQ: begin
            // data_ok before the address is accepted is a protocol error
            // and deliberately has no effect here
            if (bus_addr_ok) begin
               bus_req_d = 1'b0;
               if (bus_data_ok) begin
                  if (!bus_wr_q) begin
                     cpu_rdata_d = bus_rdata;
                  end
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (bus_data_ok) begin
               if (!bus_wr_q) begin
                  cpu_rdata_d = bus_rdata;
               end
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            bus_req_d = 1'b0;
            state_d   = ST_IDLE;
         end
      endcase
   end

   // Saturating count of stalled cycles
   always_comb begin
      stall_cycles_d = stall_cycles_q;
      if (stall && (stall_cycles_q != {CNT_W{1'b1}})) begin
         stall_cycles_d = stall_cycles_q + CNT_W'(1);
      end
   end

   // State and output registers; reset abandons any in-flight transaction
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q        <= ST_IDLE;
         bus_req_q      <= 1'b0;
         bus_wr_q       <= 1'b0;
         bus_size_q     <= 2'd0;
         bus_addr_q     <= '0;
         bus_wdata_q    <= '0;
         cpu_rdata_q    <= '0;
         stall_cycles_q <= '0;
      end else begin
         state_q        <= state_d;
         bus_req_q      <= bus_req_d;
         bus_wr_q       <= bus_wr_d;
         bus_size_q     <= bus_size_d;
         bus_addr_q     <= bus_addr_d;
         bus_wdata_q    <= bus_wdata_d;
         cpu_rdata_q    <= cpu_rdata_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign cpu_rdata    = cpu_rdata_q;
   assign cpu_stall    = stall;
   assign bus_req      = bus_req_q;
   assign bus_wr       = bus_wr_q;
   assign bus_size     = bus_size_q;
   assign bus_addr     = bus_addr_q;
   assign bus_wdata    = bus_wdata_q;
   assign stall_cycles = stall_cycles_q;

endmodule : data_sram_like_bridge
`default_nettype wire

// File: tb/tb_data_sram_like_bridge.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module      : tb_data_sram_like_bridge
//  Description : Self-checking bench for data_sram_like_bridge. A table of
//                directed transactions with hand-computed results plus
//                sequences for back-to-back reads, reset in WAIT and counter
//                saturation (second instance with a 4-bit counter).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_sram_like_bridge;

   logic        clk = 1'b0;
   logic        resetn;
   logic        cpu_en;
   logic [3:0]  cpu_wen;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic        bus_addr_ok;
   logic        bus_data_ok;
   logic [31:0] bus_rdata;

   logic [31:0] cpu_rdata;
   logic        cpu_stall;
   logic        bus_req;
   logic        bus_wr;
   logic [1:0]  bus_size;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [15:0] stall_cycles;

   logic [31:0] s_cpu_rdata;
   logic        s_cpu_stall;
   logic        s_bus_req;
   logic        s_bus_wr;
   logic [1:0]  s_bus_size;
   logic [31:0] s_bus_addr;
   logic [31:0] s_bus_wdata;
   logic [3:0]  s_stall_cycles;

   int errors = 0;
   int checks = 0;
   int req_starts = 0;
   logic req_prev = 1'b0;

   always #5 clk = ~clk;

   data_sram_like_bridge #(.ADDR_W(32), .DATA_W(32), .CNT_W(16)) dut (
      .clk(clk), .resetn(resetn),
      .cpu_en(cpu_en), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
      .bus_rdata(bus_rdata), .stall_cycles(stall_cycles)
   );

   data_sram_like_bridge #(.ADDR_W(32), .DATA_W(32), .CNT_W(4)) dut_sat (
      .clk(clk), .resetn(resetn),
      .cpu_en(cpu_en), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(s_cpu_rdata), .cpu_stall(s_cpu_stall),
      .bus_req(s_bus_req), .bus_wr(s_bus_wr), .bus_size(s_bus_size), .bus_addr(s_bus_addr),
      .bus_wdata(s_bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
      .bus_rdata(bus_rdata), .stall_cycles(s_stall_cycles)
   );

   // Count rising edges of bus_req to detect duplicate requests
   always @(negedge clk) begin
      if (bus_req && !req_prev) req_starts <= req_starts + 1;
      req_prev <= bus_req;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // One transaction: starts at posedge+1 with the bridge in IDLE, answers
   // addr_ok after aok REQ cycles and data_ok dok cycles after acceptance
   task automatic run_txn(input logic [3:0] wen, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int aok, input int dok, input bit keep_en,
                          output int nstall, output int nreq, output logic req0,
                          output logic s_wr, output logic [1:0] s_size, output bit stable,
                          output logic [31:0] rd, output logic [31:0] cnt);
      bit acc  = 0;
      bit done = 0;
      int wcnt = 0;
      nstall = 0; nreq = 0; req0 = 1'b0; s_wr = 1'b0; s_size = 2'd0;
      stable = 1; rd = '0; cnt = '0;
      cpu_en = 1'b1; cpu_wen = wen; cpu_addr = addr; cpu_wdata = wdata;
      bus_rdata = rdata;
      for (int c = 0; c < 200; c++) begin
         bus_addr_ok = 1'b0;
         bus_data_ok = 1'b0;
         if (acc) begin
            wcnt++;
            if (wcnt == dok) bus_data_ok = 1'b1;
         end else if (bus_req) begin
            if (nreq == aok) begin
               bus_addr_ok = 1'b1;
               acc = 1;
               if (dok == 0) bus_data_ok = 1'b1;
            end
         end
         @(negedge clk);
         if (c == 0) req0 = bus_req;
         if (bus_req) begin
            if (nreq == 0) begin
               s_wr = bus_wr; s_size = bus_size;
            end else if (bus_wr !== s_wr || bus_size !== s_size) begin
               stable = 0;
            end
            if (bus_addr !== addr || bus_wdata !== wdata) stable = 0;
            nreq++;
         end
         if (cpu_stall) nstall++;
         else begin
            rd = cpu_rdata; cnt = 32'(stall_cycles); done = 1;
         end
         @(posedge clk); #1;
         bus_addr_ok = 1'b0;
         bus_data_ok = 1'b0;
         if (done) break;
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL txn_timeout: got no DONE expected DONE within 200 cycles");
      end
      if (!keep_en) cpu_en = 1'b0;
   endtask

   typedef struct {
      logic [3:0]  wen;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          aok;
      int          dok;
      logic        exp_wr;
      logic [1:0]  exp_size;
      int          exp_stall;
      int          exp_nreq;
      logic [31:0] exp_rdata;
      int          exp_cnt;
   } vec_t;

   vec_t vt[10];

   initial begin
      int nstall, nreq, rs0;
      logic req0, s_wr;
      logic [1:0] s_size;
      bit stable;
      logic [31:0] rd, cnt;

      //        wen      addr          wdata         rdata         aok dok wr    size  stl nrq rdata exp      cnt
      vt[0] = '{4'b0000, 32'h1FC00010, 32'h00000000, 32'hDEADBEEF, 0, 0, 1'b0, 2'd2, 2, 1, 32'hDEADBEEF, 2};
      vt[1] = '{4'b0100, 32'h80000002, 32'h00AB0000, 32'h11111111, 3, 2, 1'b1, 2'd0, 7, 4, 32'hDEADBEEF, 9};
      vt[2] = '{4'b1100, 32'h80000010, 32'hABCD0000, 32'h22222222, 1, 0, 1'b1, 2'd1, 3, 2, 32'hDEADBEEF, 12};
      vt[3] = '{4'b0000, 32'h1FC00020, 32'h00000000, 32'h12345678, 2, 1, 1'b0, 2'd2, 5, 3, 32'h12345678, 17};
      vt[4] = '{4'b0001, 32'h80000004, 32'h000000C1, 32'h33333333, 0, 1, 1'b1, 2'd0, 3, 1, 32'h12345678, 20};
      vt[5] = '{4'b0010, 32'h80000005, 32'h0000C200, 32'h44444444, 0, 0, 1'b1, 2'd0, 2, 1, 32'h12345678, 22};
      vt[6] = '{4'b1000, 32'h80000007, 32'hC3000000, 32'h55555555, 1, 3, 1'b1, 2'd0, 6, 2, 32'h12345678, 28};
      vt[7] = '{4'b0011, 32'h80000008, 32'h0000C4C4, 32'h66666666, 0, 0, 1'b1, 2'd1, 2, 1, 32'h12345678, 30};
      vt[8] = '{4'b1111, 32'h8000000C, 32'hCAFEF00D, 32'h77777777, 0, 0, 1'b1, 2'd2, 2, 1, 32'h12345678, 32};
      vt[9] = '{4'b0101, 32'h80000010, 32'h00C500C5, 32'h88888888, 0, 0, 1'b1, 2'd2, 2, 1, 32'h12345678, 34};

      resetn = 1'b0; cpu_en = 1'b0; cpu_wen = '0; cpu_addr = '0; cpu_wdata = '0;
      bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_rdata", cpu_rdata, 32'h0);
      chk("rst_stall", 32'(cpu_stall), 32'h0);
      chk("rst_req",   32'(bus_req), 32'h0);
      chk("rst_wr",    32'(bus_wr), 32'h0);
      chk("rst_size",  32'(bus_size), 32'h0);
      chk("rst_addr",  bus_addr, 32'h0);
      chk("rst_wdata", bus_wdata, 32'h0);
      chk("rst_cnt",   32'(stall_cycles), 32'h0);
      resetn = 1'b1;
      @(posedge clk); #1;

      // Table-driven transactions
      for (int i = 0; i < 10; i++) begin
         run_txn(vt[i].wen, vt[i].addr, vt[i].wdata, vt[i].rdata, vt[i].aok, vt[i].dok, 1'b0,
                 nstall, nreq, req0, s_wr, s_size, stable, rd, cnt);
         chk($sformatf("v%0d_stall", i), 32'(nstall), 32'(vt[i].exp_stall));
         chk($sformatf("v%0d_nreq", i), 32'(nreq), 32'(vt[i].exp_nreq));
         chk($sformatf("v%0d_wr", i), 32'(s_wr), 32'(vt[i].exp_wr));
         chk($sformatf("v%0d_size", i), 32'(s_size), 32'(vt[i].exp_size));
         chk($sformatf("v%0d_stable", i), 32'(stable), 32'h1);
         chk($sformatf("v%0d_rdata", i), rd, vt[i].exp_rdata);
         chk($sformatf("v%0d_cnt", i), cnt, 32'(vt[i].exp_cnt));
      end

      // Back-to-back reads with cpu_en held high across DONE
      rs0 = req_starts;
      run_txn(4'b0000, 32'h1FC00040, 32'h0, 32'hAAAA0001, 0, 0, 1'b1,
              nstall, nreq, req0, s_wr, s_size, stable, rd, cnt);
      chk("b2b_rd1", rd, 32'hAAAA0001);
      chk("b2b_stall1", 32'(nstall), 32'd2);
      run_txn(4'b0000, 32'h1FC00044, 32'h0, 32'hBBBB0002, 0, 0, 1'b0,
              nstall, nreq, req0, s_wr, s_size, stable, rd, cnt);
      chk("b2b_req_after_done", 32'(req0), 32'h0);
      chk("b2b_stall2", 32'(nstall), 32'd2);
      chk("b2b_rd2", rd, 32'hBBBB0002);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("b2b_req_count", 32'(req_starts - rs0), 32'd2);
      chk("b2b_idle_stall", 32'(cpu_stall), 32'h0);

      // Reset asserted while waiting for data
      @(posedge clk); #1;
      cpu_en = 1'b1; cpu_wen = 4'b0000; cpu_addr = 32'h1FC00080; cpu_wdata = '0;
      @(posedge clk); #1;
      cpu_en = 1'b1; bus_addr_ok = 1'b1;
      @(posedge clk); #1;
      bus_addr_ok = 1'b0;
      chk("wait_stall", 32'(cpu_stall), 32'h1);
      chk("wait_req", 32'(bus_req), 32'h0);
      #2;
      resetn = 1'b0; cpu_en = 1'b0;
      #1;
      chk("arst_rdata", cpu_rdata, 32'h0);
      chk("arst_stall", 32'(cpu_stall), 32'h0);
      chk("arst_req", 32'(bus_req), 32'h0);
      chk("arst_addr", bus_addr, 32'h0);
      chk("arst_cnt", 32'(stall_cycles), 32'h0);
      @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;
      @(posedge clk); #1;
      bus_data_ok = 1'b1; bus_rdata = 32'hBAD0BAD0;
      @(posedge clk); #1;
      bus_data_ok = 1'b0;
      @(negedge clk);
      chk("late_dok_rdata", cpu_rdata, 32'h0);
      chk("late_dok_stall", 32'(cpu_stall), 32'h0);
      chk("late_dok_req", 32'(bus_req), 32'h0);
      @(posedge clk); #1;

      // 20-cycle stalled read: 1 IDLE + 18 REQ + 1 WAIT
      run_txn(4'b0000, 32'h1FC00100, 32'h0, 32'h0F0F0F0F, 17, 1, 1'b0,
              nstall, nreq, req0, s_wr, s_size, stable, rd, cnt);
      chk("sat_stall", 32'(nstall), 32'd20);
      chk("sat_cnt16", cnt, 32'd20);
      chk("sat_rdata", rd, 32'h0F0F0F0F);
      @(negedge clk);
      chk("sat_cnt4", 32'(s_stall_cycles), 32'd15);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_data_sram_like_bridge
`default_nettype wire
